adder_acc_pipe: RTL



---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_core.sv | 40 ++++
 rtl/adder_acc_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared mode encoding and result record for the add/sub/accumulate datapath
package adder_pkg;
  localparam int MAX_WIDTH = 64;
  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
  } res_t;
endpackage

// File: rtl/adder_core.sv
// adder_core: combinational add/sub/accumulate/load with flags; ADDER_ACC_SAT_EN enables signed saturation
module adder_core
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e             mode_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [WIDTH-1:0]  acc_i,
  output res_t              res_o
);
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   raw;
  logic             ovf;
  // ACC adds the operand onto the accumulator, so the accumulator plays the role of A
  always_comb begin
    opa = (mode_i == MODE_ACC) ? acc_i : a_i;
    opb = (mode_i == MODE_ACC) ? a_i : b_i;
    raw = (mode_i == MODE_SUB) ? {1'b0, opa} - {1'b0, opb} : {1'b0, opa} + {1'b0, opb};
    ovf = ((mode_i == MODE_SUB) ? (opa[WIDTH-1] != opb[WIDTH-1]) : (opa[WIDTH-1] == opb[WIDTH-1]))
          && (raw[WIDTH-1] != opa[WIDTH-1]);
  end
  // flags always come from the unsaturated result; LOAD passes A through with clear flags
  always_comb begin
    res_o = '0;
    if (mode_i == MODE_LOAD) begin
      res_o.sum[WIDTH-1:0] = a_i;
    end else begin
      res_o.sum[WIDTH-1:0] = raw[WIDTH-1:0];
      res_o.carry          = raw[WIDTH];
      res_o.ovf            = ovf;
`ifdef ADDER_ACC_SAT_EN
      if (ovf)
        res_o.sum[WIDTH-1:0] = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end
  end
endmodule

// File: rtl/adder_acc_pipe.sv
// adder_acc_pipe: two-stage valid/ready add/sub/accumulate pipeline (optional saturation via ADDER_ACC_SAT_EN)
module adder_acc_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  mode_e            mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             s2_load;
  logic             in_fire;
  res_t             res;

  adder_core #(.WIDTH(WIDTH)) u_core (
    .mode_i (mode_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .acc_i  (acc_q),
    .res_o  (res)
  );

  if (WIDTH < MAX_WIDTH) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^res.sum[MAX_WIDTH-1:WIDTH];
  end

  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

  // next state: stage 1 captures operands, stage 2 captures the result and retires on a consumer accept
  always_comb begin
    s1_valid_d  = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    a_d         = in_fire ? in_a : a_q;
    b_d         = in_fire ? in_b : b_q;
    mode_d      = in_fire ? mode_e'(in_mode) : mode_q;
    out_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    sum_d       = s2_load ? res.sum[WIDTH-1:0] : sum_q;
    carry_d     = s2_load ? res.carry : carry_q;
    ovf_d       = s2_load ? res.ovf : ovf_q;
    acc_d       = (s2_load && (mode_q == MODE_ACC || mode_q == MODE_LOAD)) ? res.sum[WIDTH-1:0] : acc_q;
  end

  // pipeline and accumulator registers; reset discards in-flight beats and clears acc
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_ADD;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end
endmodule
